// File: rtl/sdram_burst_fifo.sv
// Write-data FIFO feeding the SDRAM burst engine: 1-cycle write-to-flag latency, normal or show-ahead read.
// Writes are rejected when full and reads when empty; SDRAM_BURST_FIFO_ERR_EN adds sticky overflow/underflow.
module sdram_burst_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 6,
  parameter int BURST_LEN  = 8,
  parameter int AF_LEVEL   = 56,
  parameter int SHOWAHEAD  = 0
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic [WIDTH-1:0]      data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [WIDTH-1:0]      q,
  output logic [DEPTH_LOG2:0]   usedw,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  burst_rdy,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_W = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   BL_W    = (DEPTH_LOG2+1)'(BURST_LEN);
  localparam logic [DEPTH_LOG2:0]   AF_W    = (DEPTH_LOG2+1)'(AF_LEVEL);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [DEPTH_LOG2:0]   usedw_nxt;
  logic [WIDTH-1:0]      q_nxt;
  logic                  wr_ok, rd_ok;

  always_comb begin
    wr_ok     = wrreq && !full;
    rd_ok     = rdreq && !empty;
    rd_nxt    = rd_ok ? rd_ptr + PTR_ONE : rd_ptr;
    usedw_nxt = usedw;
    if (wr_ok && !rd_ok)
      usedw_nxt = usedw + CNT_ONE;
    else if (rd_ok && !wr_ok)
      usedw_nxt = usedw - CNT_ONE;
    q_nxt = q;
    if (SHOWAHEAD != 0) begin
      // Next head may be the word being written this edge (empty, or last word popped).
      if (usedw_nxt != '0)
        q_nxt = (wr_ok && rd_nxt == wr_ptr) ? data : mem[rd_nxt];
    end else if (rd_ok) begin
      q_nxt = mem[rd_ptr];
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok)
      mem[wr_ptr] <= data;
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      usedw       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      burst_rdy   <= 1'b0;
      q           <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr      <= rd_nxt;
      usedw       <= usedw_nxt;
      empty       <= (usedw_nxt == '0);
      full        <= (usedw_nxt == DEPTH_W);
      almost_full <= (usedw_nxt >= AF_W);
      burst_rdy   <= (usedw_nxt >= BL_W);
      q           <= q_nxt;
    end
  end

`ifdef SDRAM_BURST_FIFO_ERR_EN
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wrreq && full)
        overflow <= 1'b1;
      if (rdreq && empty)
        underflow <= 1'b1;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_burst_fifo.sv
// Directed bench: one normal-mode and one show-ahead FIFO, default geometry.
module tb_sdram_burst_fifo;

`ifdef SDRAM_BURST_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        aclr_n;
  logic [15:0] data, s_data;
  logic        wrreq, rdreq, s_wrreq, s_rdreq, err_clr, s_err_clr;
  logic [15:0] q, s_q;
  logic [6:0]  usedw, s_usedw;
  logic        empty, full, af, br, ovf, udf;
  logic        s_empty, s_full, s_af, s_br, s_ovf, s_udf;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] model [$];
  logic [15:0] exp_n;

  always #5 clock = ~clock;

  sdram_burst_fifo #(.SHOWAHEAD(0)) dut (
    .clock(clock), .aclr_n(aclr_n), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q), .usedw(usedw), .empty(empty), .full(full), .almost_full(af),
    .burst_rdy(br), .err_clr(err_clr), .overflow(ovf), .underflow(udf));

  sdram_burst_fifo #(.SHOWAHEAD(1)) dsa (
    .clock(clock), .aclr_n(aclr_n), .data(s_data), .wrreq(s_wrreq), .rdreq(s_rdreq),
    .q(s_q), .usedw(s_usedw), .empty(s_empty), .full(s_full), .almost_full(s_af),
    .burst_rdy(s_br), .err_clr(s_err_clr), .overflow(s_ovf), .underflow(s_udf));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " usedw"}, 32'(usedw), 0);
    check_eq({tag, " empty"}, 32'(empty), 1);
    check_eq({tag, " full"},  32'(full), 0);
    check_eq({tag, " af"},    32'(af), 0);
    check_eq({tag, " br"},    32'(br), 0);
    check_eq({tag, " q"},     32'(q), 0);
    check_eq({tag, " ovf"},   32'(ovf), 0);
    check_eq({tag, " udf"},   32'(udf), 0);
    check_eq({tag, " s_q"},   32'(s_q), 0);
    check_eq({tag, " s_empty"}, 32'(s_empty), 1);
  endtask

  initial begin
    aclr_n = 1'b0;
    data = '0; wrreq = 0; rdreq = 0; err_clr = 0;
    s_data = '0; s_wrreq = 0; s_rdreq = 0; s_err_clr = 0;
    #12;
    check_reset_outputs("reset");
    aclr_n = 1'b1;

    // Fill with 0x0000..0x003F, checking thresholds at every level.
    for (int i = 0; i < 64; i++) begin
      data = 16'(i); wrreq = 1;
      tick;
      check_eq("fill usedw", 32'(usedw), 32'(i + 1));
      check_eq("fill br",    32'(br),    32'(i + 1 >= 8));
      check_eq("fill af",    32'(af),    32'(i + 1 >= 56));
      check_eq("fill full",  32'(full),  32'(i + 1 == 64));
      check_eq("fill empty", 32'(empty), 0);
    end

    // Full with simultaneous request: read wins, write rejected.
    data = 16'hFFFF; wrreq = 1; rdreq = 1;
    tick;
    wrreq = 0; rdreq = 0;
    check_eq("full rw usedw", 32'(usedw), 63);
    check_eq("full rw full",  32'(full), 0);
    check_eq("full rw q",     32'(q), 16'h0000);
    check_eq("full rw ovf",   32'(ovf), 32'(ERR));
    err_clr = 1;
    tick;
    err_clr = 0;
    check_eq("ovf clr", 32'(ovf), 0);

    // Drain: data order and thresholds on the way down; rejected write word must never appear.
    rdreq = 1;
    for (int i = 1; i < 64; i++) begin
      tick;
      check_eq("drain q",  32'(q),  32'(i));
      check_eq("drain br", 32'(br), 32'(63 - i >= 8));
      check_eq("drain af", 32'(af), 32'(63 - i >= 56));
    end
    check_eq("drained empty", 32'(empty), 1);
    check_eq("drained usedw", 32'(usedw), 0);
    tick;
    rdreq = 0;
    check_eq("underrun q hold", 32'(q), 16'h003F);
    check_eq("underrun usedw",  32'(usedw), 0);
    check_eq("underrun udf",    32'(udf), 32'(ERR));
    err_clr = 1;
    tick;
    err_clr = 0;
    check_eq("udf clr", 32'(udf), 0);

    // Normal mode two-word read.
    data = 16'hA5A5; wrreq = 1; tick;
    data = 16'h5A5A; tick;
    wrreq = 0;
    check_eq("norm q before read", 32'(q), 16'h003F);
    rdreq = 1; tick;
    check_eq("norm q1", 32'(q), 16'hA5A5);
    tick;
    rdreq = 0;
    check_eq("norm q2",    32'(q), 16'h5A5A);
    check_eq("norm empty", 32'(empty), 1);

    // Show-ahead: first word visible with empty deasserting, bypass at occupancy 1.
    s_data = 16'h1234; s_wrreq = 1; tick;
    s_wrreq = 0;
    check_eq("sa first empty", 32'(s_empty), 0);
    check_eq("sa first q",     32'(s_q), 16'h1234);
    s_rdreq = 1; tick;
    s_rdreq = 0;
    check_eq("sa pop empty", 32'(s_empty), 1);
    check_eq("sa pop q",     32'(s_q), 16'h1234);
    s_data = 16'h1111; s_wrreq = 1; tick;
    check_eq("sa w1 q", 32'(s_q), 16'h1111);
    s_data = 16'h2222; tick;
    check_eq("sa w2 q", 32'(s_q), 16'h1111);
    s_data = 16'h3333; s_rdreq = 1; tick;
    check_eq("sa rw q",     32'(s_q), 16'h2222);
    check_eq("sa rw usedw", 32'(s_usedw), 2);
    s_wrreq = 0; tick;
    check_eq("sa pop2 q", 32'(s_q), 16'h3333);
    s_data = 16'h4444; s_wrreq = 1; tick;
    check_eq("sa bypass q",     32'(s_q), 16'h4444);
    check_eq("sa bypass usedw", 32'(s_usedw), 1);
    s_wrreq = 0; tick;
    s_rdreq = 0;
    check_eq("sa last empty", 32'(s_empty), 1);
    check_eq("sa last q",     32'(s_q), 16'h4444);

    // Streaming at occupancy 32 across pointer wrap, both modes driven identically.
    aclr_n = 0; #2; aclr_n = 1;
    model.delete();
    for (int i = 0; i < 32; i++) begin
      data = 16'(16'h0100 + i); s_data = data; wrreq = 1; s_wrreq = 1;
      model.push_back(data);
      tick;
    end
    check_eq("stream fill usedw", 32'(usedw), 32);
    rdreq = 1; s_rdreq = 1;
    for (int k = 0; k < 200; k++) begin
      data = 16'(16'h0200 + k); s_data = data;
      exp_n = model.pop_front();
      model.push_back(data);
      tick;
      check_eq("stream q",       32'(q),       32'(exp_n));
      check_eq("stream s_q",     32'(s_q),     32'(model[0]));
      check_eq("stream usedw",   32'(usedw),   32);
      check_eq("stream s_usedw", 32'(s_usedw), 32);
    end
    wrreq = 0; rdreq = 0; s_wrreq = 0; s_rdreq = 0;
    check_eq("stream ovf",   32'(ovf), 0);
    check_eq("stream udf",   32'(udf), 0);
    check_eq("stream s_ovf", 32'(s_ovf), 0);
    check_eq("stream s_udf", 32'(s_udf), 0);

    // Asynchronous reset mid-stream at occupancy 20.
    aclr_n = 0; #2; aclr_n = 1;
    for (int i = 0; i < 20; i++) begin
      data = 16'(16'h0300 + i); wrreq = 1;
      tick;
    end
    check_eq("pre-reset usedw", 32'(usedw), 20);
    rdreq = 1; data = 16'h0400;
    tick;
    check_eq("pre-reset q", 32'(q), 16'h0300);
    #3;
    aclr_n = 0;
    #1;
    check_reset_outputs("async reset");
    wrreq = 0; rdreq = 0;
    #2;
    aclr_n = 1;
    data = 16'hBEEF; wrreq = 1; tick;
    wrreq = 0;
    check_eq("post-reset usedw", 32'(usedw), 1);
    rdreq = 1; tick;
    rdreq = 0;
    check_eq("post-reset q",     32'(q), 16'hBEEF);
    check_eq("post-reset empty", 32'(empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
